// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA wrapper result path.
//   RSA_WORD_W      width of one result word
//   NUM_WORDS_1024  words per 1024-bit result
//   NUM_WORDS_2048  words per 2048-bit result
//   drain_state_e   result drain FSM states
//   word_addr()     byte address of word idx relative to a base (mod 2^32)
package rsa_pkg;

  localparam int unsigned RSA_WORD_W     = 32;
  localparam int unsigned NUM_WORDS_1024 = 32;
  localparam int unsigned NUM_WORDS_2048 = 64;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StDrain
  } drain_state_e;

  function automatic logic [RSA_WORD_W-1:0] word_addr(logic [RSA_WORD_W-1:0] base,
                                                      logic [RSA_WORD_W-1:0] idx);
    // Plain 32-bit add: wraps silently past 0xFFFF_FFFF.
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/rsa_result_drain_if.sv
// Data-path bundle of the result drain.
//   rd_fifo_en  read strobe toward the CS result FIFO
//   data_cs_i   CS FIFO data, valid one cycle after rd_fifo_en
//   wr_valid    result RAM write request
//   wr_addr     byte address of the write
//   wr_data     result word
//   wr_ready    result RAM accept
// master: the drain block; slave: the FIFO / RAM side.
interface rsa_result_drain_if;
  import rsa_pkg::*;

  logic                  rd_fifo_en;
  logic [RSA_WORD_W-1:0] data_cs_i;
  logic                  wr_valid;
  logic [RSA_WORD_W-1:0] wr_addr;
  logic [RSA_WORD_W-1:0] wr_data;
  logic                  wr_ready;

  modport master (
    output rd_fifo_en,
    input  data_cs_i,
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  rd_fifo_en,
    output data_cs_i,
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/rsa_skid_buf2.sv
// Two-entry FIFO that absorbs FIFO read data while the RAM write port stalls.
//   clk, rstn  clock, asynchronous active-low reset
//   push_i     write data_i (caller guarantees space)
//   pop_i      drop the head entry (ignored when empty)
//   data_i     entry to write
//   occ_o      number of stored entries, 0..2
//   head_o     oldest entry
module rsa_skid_buf2 #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [1:0]       occ_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;
  logic             do_pop;

  assign do_pop = pop_i && (occ_q != 2'd0);
  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      // When full, push+pop writes the slot being vacated this same cycle.
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, do_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  no_overflow_a: assert property (@(posedge clk) disable iff (!rstn)
    !(push_i && !do_pop && occ_q == 2'd2));

endmodule

// File: rtl/rsa_result_drain.sv
// Drains NUM_WORDS result words from the CS FIFO after the wrapper signals done and
// writes them as an addressed valid/ready stream into result RAM.
//   clk, rstn    clock, asynchronous active-low reset
//   start        one-cycle pulse, arms for one result (ignored while busy)
//   result_base  byte base address, captured on an accepted start
//   done         wrapper done level; its rising edge starts the drain
//   bus          FIFO read strobe/data and RAM write stream (master side)
//   busy         high while armed or draining
//   stat_done    sticky completion flag
//   err_overlap  sticky: done rose again during a drain
//   irq          one-cycle completion pulse
//   words_out    words accepted by RAM in the current operation
module rsa_result_drain
  import rsa_pkg::*;
#(
  parameter int unsigned NUM_WORDS = NUM_WORDS_1024,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [RSA_WORD_W-1:0] result_base,
  input  logic                  done,
  rsa_result_drain_if.master    bus,
  output logic                  busy,
  output logic                  stat_done,
  output logic                  err_overlap,
  output logic                  irq,
  output logic [CNT_W-1:0]      words_out
);

  localparam logic [CNT_W-1:0] NumWordsC = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LastIdx   = CNT_W'(NUM_WORDS - 1);

  drain_state_e          state_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  irq_q;
  logic                  stat_done_q;
  logic                  err_overlap_q;
  logic [RSA_WORD_W-1:0] base_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic [CNT_W-1:0]      wr_cnt_q;
  // One bit per outstanding read; the top bit marks data arriving this cycle.
  logic [RD_LAT-1:0]     rd_pipe_q;

  logic [1:0]            occ;
  logic [RSA_WORD_W-1:0] head;
  logic                  done_rise;
  logic                  room;
  logic                  rd_en;
  logic                  accept;
  logic                  last_accept;

  always_comb begin
    done_rise   = done & ~done_q;
    // Buffered plus in-flight words must stay within the two skid slots.
    room        = (int'(occ) + $countones(rd_pipe_q)) < 2;
    rd_en       = (state_q == StDrain) && (rd_cnt_q < NumWordsC) && room;
    accept      = (occ != 2'd0) && bus.wr_ready;
    last_accept = accept && (wr_cnt_q == LastIdx);
  end

  rsa_skid_buf2 #(
    .Width (RSA_WORD_W)
  ) u_skid (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (rd_pipe_q[RD_LAT-1]),
    .pop_i  (accept),
    .data_i (bus.data_cs_i),
    .occ_o  (occ),
    .head_o (head)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      irq_q         <= 1'b0;
      stat_done_q   <= 1'b0;
      err_overlap_q <= 1'b0;
      base_q        <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      rd_pipe_q     <= '0;
    end else begin
      done_q    <= done;
      irq_q     <= 1'b0;
      rd_pipe_q <= (rd_pipe_q << 1) | RD_LAT'(rd_en);
      if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if (accept) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
      case (state_q)
        StIdle: begin
          // A done edge coinciding with start is absorbed by done_q here.
          if (start) begin
            state_q       <= StArm;
            base_q        <= result_base;
            stat_done_q   <= 1'b0;
            err_overlap_q <= 1'b0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            busy_q        <= 1'b1;
          end
        end
        StArm: begin
          if (done_rise) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (done_rise) begin
            err_overlap_q <= 1'b1;
          end
          if (last_accept) begin
            state_q     <= StIdle;
            irq_q       <= 1'b1;
            stat_done_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_fifo_en = rd_en;
  assign bus.wr_valid   = (occ != 2'd0);
  assign bus.wr_data    = head;
  assign bus.wr_addr    = word_addr(base_q, RSA_WORD_W'(wr_cnt_q));

  assign busy        = busy_q;
  assign stat_done   = stat_done_q;
  assign err_overlap = err_overlap_q;
  assign irq         = irq_q;
  assign words_out   = wr_cnt_q;

endmodule
